// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

    localparam int DATA_W           = 32;
    localparam int ADDR_W           = 32;
    localparam int LOCK_MAX_DEFAULT = 4;

    // Access walk: a request is taken in IDLE, drives memory in ACCESS,
    // and is acknowledged in RESP.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // One latched word access as seen by the data memory.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } access_t;

    // Width of a counter that must hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// rr_pick2: combinational 2-way chooser. Round-robin between two requesters,
// overridden by a lock streak held by the previous owner, and produces the
// lock streak count that goes with the chosen winner.
module rr_pick2
    import mem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT,
    parameter int CNT_W    = cnt_width(LOCK_MAX)
) (
    input  logic [1:0]       req_i,
    input  logic [1:0]       lock_i,
    input  logic             ptr_i,
    input  logic             owner_i,
    input  logic             owner_locked_i,
    input  logic [CNT_W-1:0] lock_cnt_i,
    output logic             grant_o,
    output logic             winner_o,
    output logic [CNT_W-1:0] lock_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    logic other;
    logic hold;

    assign other = ~owner_i;
    // The previous owner keeps a claim only if it was locked at its grant
    // and is still asking.
    assign hold  = owner_locked_i & req_i[owner_i];

    // Winner selection and lock streak bookkeeping
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // if/else chain can leave one unassigned and infer a latch.
        grant_o    = |req_i;
        winner_o   = 1'b0;
        lock_cnt_o = '0;

        if (hold && (lock_cnt_i < CNT_MAX)) begin
            winner_o = owner_i;
        end else if (hold) begin
            // Streak exhausted: yield if the other side wants the memory,
            // otherwise the owner simply carries on.
            winner_o = req_i[other] ? other : owner_i;
        end else if (&req_i) begin
            winner_o = ptr_i;
        end else begin
            winner_o = req_i[1];
        end

        if (!lock_i[winner_o]) begin
            lock_cnt_o = '0;
        end else if ((winner_o != owner_i) || (lock_cnt_i >= CNT_MAX)) begin
            // New owner, or an owner continuing past the limit: streak restarts.
            lock_cnt_o = CNT_W'(1);
        end else begin
            lock_cnt_o = lock_cnt_i + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two requesters sharing one combinational-read data memory.
// Every access is a fixed IDLE -> ACCESS -> RESP walk, so a request sampled
// in IDLE completes two cycles later and the memory sees at most one access
// every three cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD
);

    localparam int CNT_W = cnt_width(LOCK_MAX);

    state_e           state_q,        state_d;
    logic             ptr_q,          ptr_d;
    logic             owner_q,        owner_d;
    logic             owner_locked_q, owner_locked_d;
    logic [CNT_W-1:0] lock_cnt_q,     lock_cnt_d;
    access_t          acc_q,          acc_d;
    logic [DATA_W-1:0] rdata_q,       rdata_d;

    access_t          port0_acc;
    access_t          port1_acc;
    logic             pick_grant;
    logic             pick_winner;
    logic [CNT_W-1:0] pick_cnt;
    logic             in_resp;

    assign port0_acc = '{we: we0, addr: addr0, wdata: wdata0};
    assign port1_acc = '{we: we1, addr: addr1, wdata: wdata1};
    assign in_resp   = (state_q == RESP);

    rr_pick2 #(
        .LOCK_MAX (LOCK_MAX),
        .CNT_W    (CNT_W)
    ) u_pick (
        .req_i          ({req1, req0}),
        .lock_i         ({lock1, lock0}),
        .ptr_i          (ptr_q),
        .owner_i        (owner_q),
        .owner_locked_i (owner_locked_q),
        .lock_cnt_i     (lock_cnt_q),
        .grant_o        (pick_grant),
        .winner_o       (pick_winner),
        .lock_cnt_o     (pick_cnt)
    );

    // Next-state logic: take a grant in IDLE, capture read data at the end of ACCESS
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        owner_locked_d = owner_locked_q;
        lock_cnt_d     = lock_cnt_q;
        acc_d          = acc_q;
        rdata_d        = rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_grant) begin
                    state_d        = ACCESS;
                    owner_d        = pick_winner;
                    ptr_d          = ~pick_winner;
                    owner_locked_d = pick_winner ? lock1 : lock0;
                    lock_cnt_d     = pick_cnt;
                    acc_d          = pick_winner ? port1_acc : port0_acc;
                end
            end
            ACCESS: begin
                // Captured for writes as well; the write lands on this same edge.
                state_d = RESP;
                rdata_d = mem_RD;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers: FSM state, round-robin pointer, owner and lock streak
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= 1'b0;
            owner_q        <= 1'b0;
            owner_locked_q <= 1'b0;
            lock_cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // pre-edge values, independent of statement order.
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            owner_locked_q <= owner_locked_d;
            lock_cnt_q     <= lock_cnt_d;
        end
    end

    // Data registers: latched access and captured read word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset as well, because they drive the
            // memory bus and the read-data ports directly and must read 0
            // while reset is held.
            acc_q   <= '0;
            rdata_q <= '0;
        end else begin
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory bus and per-port completion outputs
    always_comb begin
        mem_A  = acc_q.addr;
        mem_WD = acc_q.wdata;
        mem_WE = (state_q == ACCESS) && acc_q.we;
        done0  = in_resp && !owner_q;
        done1  = in_resp &&  owner_q;
        rdata0 = (in_resp && !owner_q) ? rdata_q : '0;
        rdata1 = (in_resp &&  owner_q) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus against mem_arbiter, checked every cycle
// against a transaction-level model plus hand-computed literal expectations.
module tb_mem_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        req0   = 1'b0, we0 = 1'b0, lock0 = 1'b0;
    logic        req1   = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [31:0] addr0  = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        done0, done1, mem_WE;
    logic [31:0] rdata0, rdata1, mem_A, mem_WD, mem_RD;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk    (clk),    .rst_n  (rst_n),
        .req0   (req0),   .we0    (we0),    .addr0 (addr0), .wdata0 (wdata0),
        .lock0  (lock0),  .done0  (done0),  .rdata0 (rdata0),
        .req1   (req1),   .we1    (we1),    .addr1 (addr1), .wdata1 (wdata1),
        .lock1  (lock1),  .done1  (done1),  .rdata1 (rdata1),
        .mem_A  (mem_A),  .mem_WD (mem_WD), .mem_WE (mem_WE), .mem_RD (mem_RD)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- data memory (256 words, byte addressed) ----------------
    function automatic logic [31:0] init_word(input logic [7:0] idx);
        return (idx == 8'd4) ? 32'hDEAD_BEEF : 32'h1000_0000 + {24'd0, idx};
    endfunction

    logic [31:0] mem     [256];
    bit          mem_wr  [256];
    int          we_cnt = 0;

    assign mem_RD = mem_wr[mem_A[9:2]] ? mem[mem_A[9:2]] : init_word(mem_A[9:2]);

    always @(posedge clk) begin
        if (mem_WE) begin
            mem[mem_A[9:2]]    <= mem_WD;
            mem_wr[mem_A[9:2]] <= 1'b1;
        end
    end

    always @(negedge clk) if (mem_WE) we_cnt <= we_cnt + 1;

    // ---------------- transaction-level reference model ----------------
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];

    int          m_since  = 0;      // cycles since the grant; 0 = nothing in flight
    bit          m_owner  = 1'b0;
    bit          m_lock   = 1'b0;   // owner's lock at its grant
    int          m_streak = 0;      // consecutive locked grants of the owner
    bit          m_rr     = 1'b0;   // port that wins a tie
    bit          m_we     = 1'b0;
    logic [31:0] m_addr   = '0, m_wdata = '0, m_rdata = '0;

    function automatic bit pick_w(bit r0, bit r1, bit own, bit lk, int streak, bit rr);
        bit own_req;
        bit oth_req;
        own_req = own ? r1 : r0;
        oth_req = own ? r0 : r1;
        if (lk && own_req && streak < LOCK_MAX) return own;
        if (lk && own_req) return oth_req ? !own : own;
        if (r0 && r1) return rr;
        return r1;
    endfunction

    function automatic int next_streak(bit w, bit lkw, bit own, int streak);
        if (!lkw) return 0;
        if (w != own || streak >= LOCK_MAX) return 1;
        return streak + 1;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : init_word(a[9:2]);
    endfunction

    bit m_w;
    int m_streak_n;
    assign m_w        = pick_w(req0, req1, m_owner, m_lock, m_streak, m_rr);
    assign m_streak_n = next_streak(m_w, m_w ? lock1 : lock0, m_owner, m_streak);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_since <= 0;  m_owner <= 1'b0; m_lock <= 1'b0; m_streak <= 0; m_rr <= 1'b0;
            m_we    <= 1'b0; m_addr <= '0;  m_wdata <= '0;  m_rdata <= '0;
        end else if (m_since == 1) begin
            m_rdata <= ref_read(m_addr);
            if (m_we) begin
                ref_mem[m_addr[9:2]] <= m_wdata;
                ref_wr[m_addr[9:2]]  <= 1'b1;
            end
            m_since <= 2;
        end else if (m_since == 2) begin
            m_since <= 0;
        end else if (req0 || req1) begin
            m_since  <= 1;
            m_owner  <= m_w;
            m_lock   <= m_w ? lock1 : lock0;
            m_streak <= m_streak_n;
            m_rr     <= !m_w;
            m_we     <= m_w ? we1 : we0;
            m_addr   <= m_w ? addr1 : addr0;
            m_wdata  <= m_w ? wdata1 : wdata0;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        check("cyc_mem_WE", {31'd0, mem_WE}, {31'd0, (m_since == 1) && m_we});
        check("cyc_mem_A",  mem_A,  m_addr);
        check("cyc_mem_WD", mem_WD, m_wdata);
        check("cyc_done0",  {31'd0, done0}, {31'd0, (m_since == 2) && !m_owner});
        check("cyc_done1",  {31'd0, done1}, {31'd0, (m_since == 2) &&  m_owner});
        check("cyc_rdata0", rdata0, ((m_since == 2) && !m_owner) ? m_rdata : 32'd0);
        check("cyc_rdata1", rdata1, ((m_since == 2) &&  m_owner) ? m_rdata : 32'd0);
    end

    // ---------------- stimulus helpers ----------------
    int log_port[$];
    int log_cyc[$];

    task automatic apply_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    // One access on one port, driven in an IDLE cycle; lat counts falling
    // edges until done (3 = done in the second cycle after the sampling one).
    task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit drop_early,
                             output logic [31:0] rd, output int lat);
        @(posedge clk); #2;
        if (port) begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wdata; end
        else      begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wdata; end
        lat = 0;
        rd  = '0;
        repeat (10) begin
            @(negedge clk); #1;
            lat++;
            if (port ? done1 : done0) begin
                rd = port ? rdata1 : rdata0;
                break;
            end
            if (drop_early && lat == 2) begin
                // In ACCESS now: withdraw and scramble the request.
                if (port) begin req1 = 0; addr1 = 32'h30; wdata1 = '1; we1 = ~we; end
                else      begin req0 = 0; addr0 = 32'h30; wdata0 = '1; we0 = ~we; end
            end
        end
        if (port) req1 = 0; else req0 = 0;
    endtask

    // Log completions until n are seen; optionally raise req0 after a given count.
    task automatic collect(input int n, input int raise0_at, input int budget);
        int cyc;
        cyc = 0;
        log_port.delete();
        log_cyc.delete();
        while (log_port.size() < n && cyc < budget) begin
            @(negedge clk); #1;
            cyc++;
            if (done0 || done1) begin
                log_port.push_back(done1 ? 1 : 0);
                log_cyc.push_back(cyc);
                if (log_port.size() == raise0_at) req0 = 1'b1;
            end
        end
        check("collect_count", log_port.size(), n);
        req0 = 0;
        req1 = 0;
    endtask

    function automatic int log_at(input int i);
        return (i < log_port.size()) ? log_port[i] : 99;
    endfunction

    // ---------------- directed tests ----------------
    initial begin
        logic [31:0] rd;
        int          lat;
        int          we0_cnt;
        int          seen;
        int          exp_ctn [4] = '{0, 1, 0, 1};
        int          exp_lck [6] = '{0, 0, 0, 0, 1, 0};

        #1 rst_n = 1'b0;
        @(posedge clk); #2;
        check("rst_done0",  {31'd0, done0},  32'd0);
        check("rst_done1",  {31'd0, done1},  32'd0);
        check("rst_mem_WE", {31'd0, mem_WE}, 32'd0);
        check("rst_mem_A",  mem_A,  32'd0);
        check("rst_mem_WD", mem_WD, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        rst_n = 1'b1;

        // Single read of 0x10 on port 0.
        we0_cnt = we_cnt;
        do_access(0, 0, 32'h10, 32'h0, 0, rd, lat);
        check("read_latency", lat, 3);
        check("read_rdata0",  rd,  32'hDEAD_BEEF);
        check("read_no_WE",   we_cnt - we0_cnt, 0);

        // Single write on port 1, then read it back on port 0.
        we0_cnt = we_cnt;
        do_access(1, 1, 32'h20, 32'h1234_5678, 0, rd, lat);
        check("write_latency",  lat, 3);
        check("write_WE_count", we_cnt - we0_cnt, 1);
        check("write_old_word", rd, 32'h1000_0008);
        do_access(0, 0, 32'h20, 32'h0, 0, rd, lat);
        check("readback_0x20",  rd, 32'h1234_5678);

        // Contention from reset: strict alternation, one completion per 3 cycles.
        apply_reset();
        addr0 = 32'h10; addr1 = 32'h20; req0 = 1; req1 = 1;
        collect(4, -1, 40);
        for (int i = 0; i < 4; i++) check($sformatf("contend_order%0d", i), log_at(i), exp_ctn[i]);
        for (int i = 1; i < 4 && i < log_cyc.size(); i++)
            check($sformatf("contend_gap%0d", i), log_cyc[i] - log_cyc[i-1], 3);

        // Lock on port 0 against a permanent port 1 request.
        apply_reset();
        lock0 = 1; req0 = 1; req1 = 1;
        collect(6, -1, 60);
        for (int i = 0; i < 6; i++) check($sformatf("lock_order%0d", i), log_at(i), exp_lck[i]);
        lock0 = 0;

        // Locked port 1 alone: runs past the limit with a restarted streak,
        // so a late port 0 request waits out a fresh streak of four.
        apply_reset();
        lock1 = 1; req1 = 1; addr1 = 32'h14;
        collect(9, 5, 80);
        for (int i = 0; i < 9; i++) check($sformatf("solo_order%0d", i), log_at(i), (i == 8) ? 0 : 1);
        lock1 = 0;

        // Reset in the middle of a write: abandoned, no write, no completion.
        apply_reset();
        req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'hAAAA_5555;
        @(posedge clk); #2;
        check("abort_in_access", {31'd0, mem_WE}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_WE",    {31'd0, mem_WE}, 32'd0);
        check("abort_mem_A", mem_A,  32'd0);
        check("abort_mem_WD", mem_WD, 32'd0);
        check("abort_done1", {31'd0, done1},  32'd0);
        @(posedge clk); #2;
        req1 = 0; we1 = 0;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (done1) seen++;
        end
        check("abort_no_done1", seen, 0);
        check("abort_mem_0x40", mem_wr[16] ? mem[16] : init_word(8'd16), 32'h1000_0010);
        do_access(0, 0, 32'h40, 32'h0, 0, rd, lat);
        check("abort_readback", rd, 32'h1000_0010);

        // Requester withdraws during ACCESS: still completes with the original word.
        do_access(0, 0, 32'h14, 32'h0, 1, rd, lat);
        check("drop_latency", lat, 3);
        check("drop_rdata0",  rd,  32'h1000_0005);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
